// File: rtl/arb_mux_if.sv
// ---------------------------------------------------------------------------
// arb_mux_if -- bundle of the arbitrated-mux handshake signals.
//
// Parameters
//   WIDTH : bit width of each data channel and of mux_op
//   N     : number of input channels
//
// Signals
//   mode      : 0 = fixed priority, 1 = round-robin
//   in_data   : N*WIDTH flattened channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid  : per-channel request
//   in_ready  : per-channel accept (combinational, at most one bit high)
//   mux_op    : registered selected data
//   out_valid : registered, mux_op holds an unconsumed word
//   out_ready : downstream accept of mux_op
//   grant_q   : registered one-hot index of the channel that produced mux_op
//
// Modports
//   master : the side that drives requests/data and consumes mux_op
//   slave  : the arbiter itself
// ---------------------------------------------------------------------------
interface arb_mux_if #(
    parameter int WIDTH = 4,
    parameter int N     = 3
);
    logic                 mode;
    logic [N*WIDTH-1:0]   in_data;
    logic [N-1:0]         in_valid;
    logic [N-1:0]         in_ready;
    logic [WIDTH-1:0]     mux_op;
    logic                 out_valid;
    logic                 out_ready;
    logic [N-1:0]         grant_q;

    modport master (
        output mode,
        output in_data,
        output in_valid,
        input  in_ready,
        input  mux_op,
        input  out_valid,
        output out_ready,
        input  grant_q
    );

    modport slave (
        input  mode,
        input  in_data,
        input  in_valid,
        output in_ready,
        output mux_op,
        output out_valid,
        input  out_ready,
        output grant_q
    );
endinterface

// File: rtl/arb_mux.sv
// ---------------------------------------------------------------------------
// arb_mux -- N-channel arbiter feeding a single one-word output register.
//
// Each cycle one valid channel is chosen (fixed priority or round-robin,
// selectable per cycle through bus.mode) and, if the output register is
// empty or being drained this cycle, its data is captured into mux_op with
// one cycle of latency. grant_q records which channel produced mux_op.
//
// Ports
//   clk   : single clock, rising-edge
//   rst_n : synchronous, active-low reset
//   bus   : arb_mux_if.slave (mode, in_data, in_valid, in_ready, mux_op,
//           out_valid, out_ready, grant_q)
// ---------------------------------------------------------------------------
module arb_mux #(
    parameter int WIDTH = 4,
    parameter int N     = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    arb_mux_if.slave    bus
);
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    // registered state
    logic [WIDTH-1:0] r_mux_op;
    logic             r_out_valid;
    logic [N-1:0]     r_grant_q;
    logic [PTR_W-1:0] r_ptr;

    // combinational arbitration
    logic             w_load_en;
    logic [N-1:0]     w_fixed_grant;
    logic [N:0]       w_seen;
    logic [N-1:0]     w_rr_grant;
    logic             w_rr_found;
    logic [PTR_W:0]   w_rr_sum;
    logic [PTR_W-1:0] w_rr_pos;
    logic [N-1:0]     w_grant;
    logic [PTR_W-1:0] w_idx_chain [N+1];
    logic [WIDTH-1:0] w_data_chain [N+1];
    logic [PTR_W-1:0] w_grant_idx;
    logic [WIDTH-1:0] w_sel_data;
    logic [PTR_W-1:0] w_ptr_next;

    // The load decision only looks at handshake state, never at in_data,
    // so in_ready carries no combinational path from the data bus.
    // rst_n gates it so nothing is offered as accepted while in reset.
    assign w_load_en = rst_n && (!r_out_valid || bus.out_ready) && (|bus.in_valid);

    // Fixed priority: lowest-index valid channel, via a running "seen" prefix.
    assign w_seen[0] = 1'b0;
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_fixed
            assign w_seen[gi+1]      = w_seen[gi] | bus.in_valid[gi];
            assign w_fixed_grant[gi] = bus.in_valid[gi] & ~w_seen[gi];
        end
    endgenerate

    // Round-robin: scan ptr, ptr+1, ..., wrapping at N; first valid wins.
    always_comb begin
        w_rr_grant = '0;
        w_rr_found = 1'b0;
        w_rr_sum   = '0;
        w_rr_pos   = '0;
        for (int k = 0; k < N; k++) begin
            w_rr_sum = {1'b0, r_ptr} + (PTR_W+1)'(k);
            if (w_rr_sum >= (PTR_W+1)'(N)) begin
                w_rr_sum = w_rr_sum - (PTR_W+1)'(N);
            end
            w_rr_pos = w_rr_sum[PTR_W-1:0];
            if (!w_rr_found && bus.in_valid[w_rr_pos]) begin
                w_rr_found           = 1'b1;
                w_rr_grant[w_rr_pos] = 1'b1;
            end
        end
    end

    assign w_grant = bus.mode ? w_rr_grant : w_fixed_grant;

    // One-hot grant drives both the data select and the index encoder as
    // AND-OR chains; exactly one term can be non-zero.
    assign w_idx_chain[0]  = '0;
    assign w_data_chain[0] = '0;
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_sel
            assign w_idx_chain[gi+1]  = w_idx_chain[gi]
                                      | (w_grant[gi] ? PTR_W'(gi) : '0);
            assign w_data_chain[gi+1] = w_data_chain[gi]
                                      | ({WIDTH{w_grant[gi]}} & bus.in_data[gi*WIDTH +: WIDTH]);
        end
    endgenerate

    assign w_grant_idx = w_idx_chain[N];
    assign w_sel_data  = w_data_chain[N];

    // Next round-robin start is one past the winner, wrapping N-1 -> 0.
    assign w_ptr_next = (w_grant_idx == PTR_W'(N-1)) ? '0 : (w_grant_idx + 1'b1);

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_ready
            assign bus.in_ready[gi] = w_load_en & w_grant[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mux_op    <= '0;
            r_out_valid <= 1'b0;
            r_grant_q   <= '0;
            r_ptr       <= '0;
        end else if (w_load_en) begin
            // A new word always wins over a simultaneous drain, so
            // out_valid stays high for back-to-back transfers.
            r_mux_op    <= w_sel_data;
            r_grant_q   <= w_grant;
            r_out_valid <= 1'b1;
            if (bus.mode) begin
                r_ptr <= w_ptr_next;
            end
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.mux_op    = r_mux_op;
    assign bus.out_valid = r_out_valid;
    assign bus.grant_q   = r_grant_q;
endmodule

// File: tb/tb_arb_mux.sv
module tb_arb_mux;
    localparam int WIDTH = 4;
    localparam int N     = 3;

    logic clk;
    logic rst_n;

    arb_mux_if #(.WIDTH(WIDTH), .N(N)) bus ();

    arb_mux #(.WIDTH(WIDTH), .N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        mode;
        logic [2:0]  vld;
        logic [11:0] data;   // {ch2, ch1, ch0}
        logic        ordy;
        logic [2:0]  exp_rdy; // in_ready before the edge
        logic [3:0]  exp_mux; // registered values after the edge
        logic        exp_ov;
        logic [2:0]  exp_gq;
    } vec_t;

    localparam int NV = 23;
    vec_t tbl [NV];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic vec_t mk(logic r, logic m, logic [2:0] v, logic [11:0] d, logic o,
                                logic [2:0] er, logic [3:0] em, logic eo, logic [2:0] eg);
        vec_t t;
        t.rst_n = r; t.mode = m; t.vld = v; t.data = d; t.ordy = o;
        t.exp_rdy = er; t.exp_mux = em; t.exp_ov = eo; t.exp_gq = eg;
        return t;
    endfunction

    task automatic chk(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic m, input logic [2:0] v,
                         input logic [11:0] d, input logic o);
        rst_n         = r;
        bus.mode      = m;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = o;
    endtask

    // Called 1 time unit after a rising edge: drive, check in_ready, clock,
    // then check the registered outputs.
    task automatic step_chk(input string tag, input int s, input vec_t t);
        drive(t.rst_n, t.mode, t.vld, t.data, t.ordy);
        #1;
        chk({tag, ".in_ready"}, s, 32'(bus.in_ready), 32'(t.exp_rdy));
        @(posedge clk);
        #1;
        chk({tag, ".mux_op"},    s, 32'(bus.mux_op),    32'(t.exp_mux));
        chk({tag, ".out_valid"}, s, 32'(bus.out_valid), 32'(t.exp_ov));
        chk({tag, ".grant_q"},   s, 32'(bus.grant_q),   32'(t.exp_gq));
        $display("%s step %0d: rst_n=%0b mode=%0b vld=%b data=%h ordy=%0b -> rdy=%b mux=%0h ov=%0b gq=%b",
                 tag, s, t.rst_n, t.mode, t.vld, t.data, t.ordy,
                 t.exp_rdy, bus.mux_op, bus.out_valid, bus.grant_q);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //              rst mode vld     data    ordy rdy     mux  ov  gq
        tbl[0]  = mk(0, 0, 3'b111, 12'h321, 1, 3'b000, 4'h0, 0, 3'b000); // reset
        tbl[1]  = mk(1, 0, 3'b110, 12'h950, 1, 3'b010, 4'h5, 1, 3'b010); // fixed prio
        tbl[2]  = mk(1, 0, 3'b110, 12'h950, 1, 3'b010, 4'h5, 1, 3'b010); // stays ch1
        tbl[3]  = mk(1, 0, 3'b000, 12'h950, 1, 3'b000, 4'h5, 0, 3'b010); // drain
        tbl[4]  = mk(1, 0, 3'b010, 12'h950, 1, 3'b010, 4'h5, 1, 3'b010);
        tbl[5]  = mk(1, 0, 3'b001, 12'h957, 0, 3'b000, 4'h5, 1, 3'b010); // backpressure
        tbl[6]  = mk(1, 0, 3'b001, 12'h957, 1, 3'b001, 4'h7, 1, 3'b001); // released
        tbl[7]  = mk(1, 0, 3'b100, 12'h900, 1, 3'b100, 4'h9, 1, 3'b100);
        tbl[8]  = mk(1, 0, 3'b000, 12'h900, 1, 3'b000, 4'h9, 0, 3'b100); // drain, hold
        tbl[9]  = mk(1, 1, 3'b111, 12'h321, 1, 3'b001, 4'h1, 1, 3'b001); // RR ptr0
        tbl[10] = mk(1, 1, 3'b111, 12'h321, 1, 3'b010, 4'h2, 1, 3'b010);
        tbl[11] = mk(1, 1, 3'b111, 12'h321, 1, 3'b100, 4'h3, 1, 3'b100);
        tbl[12] = mk(1, 1, 3'b111, 12'h321, 1, 3'b001, 4'h1, 1, 3'b001); // wrap
        tbl[13] = mk(1, 1, 3'b010, 12'h321, 1, 3'b010, 4'h2, 1, 3'b010); // ptr -> 2
        tbl[14] = mk(1, 0, 3'b101, 12'h321, 1, 3'b001, 4'h1, 1, 3'b001); // mode0: ch0
        tbl[15] = mk(1, 1, 3'b101, 12'h321, 1, 3'b100, 4'h3, 1, 3'b100); // mode1: ch2
        tbl[16] = mk(1, 1, 3'b110, 12'h321, 1, 3'b010, 4'h2, 1, 3'b010); // ptr0 skip
        tbl[17] = mk(1, 1, 3'b011, 12'h321, 1, 3'b001, 4'h1, 1, 3'b001); // ptr2 wrap
        tbl[18] = mk(1, 0, 3'b001, 12'h007, 1, 3'b001, 4'h7, 1, 3'b001); // ptr held 1
        tbl[19] = mk(0, 0, 3'b111, 12'h327, 1, 3'b000, 4'h0, 0, 3'b000); // mid reset
        tbl[20] = mk(1, 1, 3'b111, 12'h321, 1, 3'b001, 4'h1, 1, 3'b001); // ptr back 0
        tbl[21] = mk(1, 1, 3'b111, 12'h321, 0, 3'b000, 4'h1, 1, 3'b001); // stall
        tbl[22] = mk(1, 1, 3'b111, 12'h321, 1, 3'b010, 4'h2, 1, 3'b010); // resume ch1

        drive(0, 0, 3'b000, 12'h000, 0);
        @(posedge clk);
        #1;

        for (int s = 0; s < NV; s++) begin
            step_chk("vec", s, tbl[s]);
        end

        // Sequence: stalled word held over several idle cycles, then drained
        // and held indefinitely with no requests.
        for (int s = 0; s < 3; s++) begin
            step_chk("idle_stall", s, mk(1, 1, 3'b000, 12'hfff, 0, 3'b000, 4'h2, 1, 3'b010));
        end
        step_chk("idle_drain", 0, mk(1, 1, 3'b000, 12'hfff, 1, 3'b000, 4'h2, 0, 3'b010));
        for (int s = 0; s < 4; s++) begin
            step_chk("idle_hold", s, mk(1, 0, 3'b000, 12'hfff, 1, 3'b000, 4'h2, 0, 3'b010));
        end

        // Sequence: reset held for several cycles with live requests; then
        // the first cycle after release acts as empty with ptr = 0.
        for (int s = 0; s < 3; s++) begin
            step_chk("rst_hold", s, mk(0, 1, 3'b111, 12'h654, 1, 3'b000, 4'h0, 0, 3'b000));
        end
        step_chk("rst_release", 0, mk(1, 1, 3'b110, 12'h654, 0, 3'b010, 4'h5, 1, 3'b010));
        step_chk("rst_release", 1, mk(1, 1, 3'b111, 12'h654, 1, 3'b100, 4'h6, 1, 3'b100));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
